// File: rtl/execute1.sv
// rtl/execute1.sv - execute pipeline stage: single-cycle ALU plus optional multiply and iterative divide
// Define EX_MULDIV_EN to build the multiplier and the restoring divider with its stall FSM.
module execute1 #(
    parameter int BUS_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [5:0]                inAluControl,
    input  logic [BUS_DATA_WIDTH-1:0] inReadData1,
    input  logic [BUS_DATA_WIDTH-1:0] inReadData2,
    input  logic [BUS_DATA_WIDTH-1:0] inImm,
    input  logic [BUS_DATA_WIDTH-1:0] inPc,
    input  logic [4:0]                inDestRegister,
    input  logic                      inRegWrite,
    input  logic                      inMemRead,
    input  logic                      inMemWrite,
    input  logic                      inMemOrReg,
    input  logic [2:0]                inLoadType,
    input  logic [1:0]                inStoreType,
    output logic [BUS_DATA_WIDTH-1:0] outAluResult,
    output logic [BUS_DATA_WIDTH-1:0] outStoreData,
    output logic [BUS_DATA_WIDTH-1:0] outPc,
    output logic [4:0]                outDestRegister,
    output logic                      outRegWrite,
    output logic                      outMemRead,
    output logic                      outMemWrite,
    output logic                      outMemOrReg,
    output logic [2:0]                outLoadType,
    output logic [1:0]                outStoreType,
    output logic                      outStallReq
);
    localparam int W  = BUS_DATA_WIDTH;
    localparam int SB = W + 14;

    logic [W-1:0]  w_a, w_b, w_alu;
    logic [SB-1:0] w_sb_in;
    logic          w_stall;
    logic [W-1:0]  r_result, r_store;
    logic [SB-1:0] r_sb;

    function automatic logic [W-1:0] sext32(input logic [31:0] v);
        return {{(W-32){v[31]}}, v};
    endfunction

    assign w_a     = inReadData1;
    assign w_sb_in = {inPc, inDestRegister, inRegWrite, inMemRead, inMemWrite, inMemOrReg,
                      inLoadType, inStoreType};

    always_comb begin
        w_b = inReadData2;
        case (inAluControl)
            6'b000001, 6'b010110, 6'b010111, 6'b011000, 6'b011001: w_b = inImm;
            default: ;
        endcase
    end

`ifdef EX_MULDIV_EN
    // Both operands extended to 2W so one unsigned multiplier covers all signedness mixes.
    logic [2*W-1:0] w_ma, w_mb, w_prod;
    logic           w_a_sx, w_b_sx;
    assign w_a_sx = (inAluControl != 6'b100010);
    assign w_b_sx = (inAluControl == 6'b100000);
    assign w_ma   = {{W{w_a_sx & w_a[W-1]}}, w_a};
    assign w_mb   = {{W{w_b_sx & w_b[W-1]}}, w_b};
    assign w_prod = w_ma * w_mb;
`endif

    always_comb begin
        w_alu = '0;
        case (inAluControl)
            6'b000001, 6'b001100: w_alu = w_a + w_b;
            6'b001101: w_alu = w_a - w_b;
            6'b001110: w_alu = w_a << w_b[5:0];
            6'b001111: w_alu = {{(W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            6'b010000: w_alu = {{(W-1){1'b0}}, (w_a < w_b)};
            6'b010001: w_alu = w_a ^ w_b;
            6'b010010: w_alu = w_a >> w_b[5:0];
            6'b010011: w_alu = $signed(w_a) >>> w_b[5:0];
            6'b010100: w_alu = w_a | w_b;
            6'b010101: w_alu = w_a & w_b;
            6'b010110, 6'b011010: w_alu = sext32(w_a[31:0] + w_b[31:0]);
            6'b011011: w_alu = sext32(w_a[31:0] - w_b[31:0]);
            6'b010111, 6'b011100: w_alu = sext32(w_a[31:0] << w_b[4:0]);
            6'b011000, 6'b011101: w_alu = sext32(w_a[31:0] >> w_b[4:0]);
            6'b011001, 6'b011110: w_alu = sext32($signed(w_a[31:0]) >>> w_b[4:0]);
`ifdef EX_MULDIV_EN
            6'b011111: w_alu = w_prod[W-1:0];
            6'b100000, 6'b100001, 6'b100010: w_alu = w_prod[2*W-1:W];
            6'b100111: w_alu = sext32(w_prod[31:0]);
`endif
            default: ;
        endcase
    end

`ifdef EX_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    state_t         r_state, w_next;
    logic [5:0]     r_count;
    logic           w_is_div, w_signed, w_word, w_is_rem, w_dvd_neg, w_dvs_neg, w_ge;
    logic [W-1:0]   w_dvd, w_dvs, w_diff, w_q, w_r, w_dres_raw, w_dres;
    logic [W:0]     w_shift;
    logic [W-1:0]   r_quo, r_rem, r_dvs, r_dstore;
    logic [SB-1:0]  r_dsb;
    logic           r_q_neg, r_r_neg, r_div_zero, r_is_rem, r_word;

    assign w_is_div  = (inAluControl inside {6'b100011, 6'b100100, 6'b100101, 6'b100110,
                                             6'b101000, 6'b101001, 6'b101010, 6'b101011});
    assign w_signed  = (inAluControl inside {6'b100011, 6'b100101, 6'b101000, 6'b101010});
    assign w_is_rem  = (inAluControl inside {6'b100101, 6'b100110, 6'b101010, 6'b101011});
    assign w_word    = inAluControl[3];
    assign w_dvd     = w_word ? {{(W-32){w_signed & w_a[31]}}, w_a[31:0]} : w_a;
    assign w_dvs     = w_word ? {{(W-32){w_signed & w_b[31]}}, w_b[31:0]} : w_b;
    assign w_dvd_neg = w_signed & w_dvd[W-1];
    assign w_dvs_neg = w_signed & w_dvs[W-1];

    // Restoring step: the quotient register doubles as the dividend shift source.
    assign w_shift = {r_rem, r_quo[W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_diff  = w_shift[W-1:0] - r_dvs;

    assign w_q        = r_div_zero ? '1 : (r_q_neg ? -r_quo : r_quo);
    assign w_r        = r_r_neg ? -r_rem : r_rem;
    assign w_dres_raw = r_is_rem ? w_r : w_q;
    assign w_dres     = r_word ? sext32(w_dres_raw[31:0]) : w_dres_raw;

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: if (w_is_div) begin
                w_next  = S_BUSY;
                w_stall = 1'b1;
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (r_count == 6'd63) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_is_div) r_count <= '0;
            else if (r_state == S_BUSY)        r_count <= r_count + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_is_div) begin
            r_quo      <= w_dvd_neg ? -w_dvd : w_dvd;
            r_dvs      <= w_dvs_neg ? -w_dvs : w_dvs;
            r_rem      <= '0;
            r_q_neg    <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg    <= w_dvd_neg;
            r_div_zero <= (w_dvs == '0);
            r_is_rem   <= w_is_rem;
            r_word     <= w_word;
            r_dsb      <= w_sb_in;
            r_dstore   <= inReadData2;
        end else if (r_state == S_BUSY) begin
            r_rem <= w_ge ? w_diff : w_shift[W-1:0];
            r_quo <= {r_quo[W-2:0], w_ge};
        end
    end
`else
    assign w_stall = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset || w_stall) begin
            r_result <= '0;
            r_store  <= '0;
            r_sb     <= '0;
`ifdef EX_MULDIV_EN
        end else if (r_state == S_DONE) begin
            r_result <= w_dres;
            r_store  <= r_dstore;
            r_sb     <= r_dsb;
`endif
        end else begin
            r_result <= w_alu;
            r_store  <= inReadData2;
            r_sb     <= w_sb_in;
        end
    end

    assign outStallReq  = w_stall;
    assign outAluResult = r_result;
    assign outStoreData = r_store;
    assign {outPc, outDestRegister, outRegWrite, outMemRead, outMemWrite, outMemOrReg,
            outLoadType, outStoreType} = r_sb;
endmodule

// File: tb/tb_execute1.sv
// tb/tb_execute1.sv - vector table and divide sequences for execute1 with a result scoreboard
module tb_execute1;
    localparam int W = 64;
`ifdef EX_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [5:0]   inAluControl;
    logic [W-1:0] inReadData1, inReadData2, inImm, inPc;
    logic [4:0]   inDestRegister;
    logic         inRegWrite, inMemRead, inMemWrite, inMemOrReg;
    logic [2:0]   inLoadType;
    logic [1:0]   inStoreType;
    logic [W-1:0] outAluResult, outStoreData, outPc;
    logic [4:0]   outDestRegister;
    logic         outRegWrite, outMemRead, outMemWrite, outMemOrReg;
    logic [2:0]   outLoadType;
    logic [1:0]   outStoreType;
    logic         outStallReq;
    logic [W+13:0] in_sb, out_sb;

    execute1 #(.BUS_DATA_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .inAluControl(inAluControl),
        .inReadData1(inReadData1), .inReadData2(inReadData2), .inImm(inImm), .inPc(inPc),
        .inDestRegister(inDestRegister), .inRegWrite(inRegWrite), .inMemRead(inMemRead),
        .inMemWrite(inMemWrite), .inMemOrReg(inMemOrReg), .inLoadType(inLoadType),
        .inStoreType(inStoreType), .outAluResult(outAluResult), .outStoreData(outStoreData),
        .outPc(outPc), .outDestRegister(outDestRegister), .outRegWrite(outRegWrite),
        .outMemRead(outMemRead), .outMemWrite(outMemWrite), .outMemOrReg(outMemOrReg),
        .outLoadType(outLoadType), .outStoreType(outStoreType), .outStallReq(outStallReq)
    );

    always #5 clk = ~clk;

    assign in_sb  = {inPc, inDestRegister, inRegWrite, inMemRead, inMemWrite, inMemOrReg,
                     inLoadType, inStoreType};
    assign out_sb = {outPc, outDestRegister, outRegWrite, outMemRead, outMemWrite, outMemOrReg,
                     outLoadType, outStoreType};

    typedef struct {
        logic [5:0]   op;
        logic [W-1:0] a, b, imm, exp;
        logic [3:0]   ctrl;
    } vec_t;
    typedef struct {
        logic [W-1:0]  res, store;
        logic [W+13:0] sb;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        e = sb_q.pop_front();
        check({tag, ".result"}, outAluResult, e.res);
        check({tag, ".store"},  outStoreData, e.store);
        check({tag, ".side"},   out_sb, e.sb);
    endtask

    task automatic drive(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] imm, input logic [W-1:0] pc, input logic [4:0] rd,
                         input logic [3:0] ctrl, input logic [2:0] lt, input logic [1:0] st);
        inAluControl = op;
        inReadData1  = a;
        inReadData2  = b;
        inImm        = imm;
        inPc         = pc;
        inDestRegister = rd;
        {inRegWrite, inMemRead, inMemWrite, inMemOrReg} = ctrl;
        inLoadType   = lt;
        inStoreType  = st;
    endtask

    task automatic bubble();
        drive(6'd0, '0, '0, '0, '0, 5'd0, 4'd0, 3'd0, 2'd0);
    endtask

    function automatic void add(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] imm, input logic [W-1:0] exp, input logic [3:0] ctrl);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.imm = imm; v.exp = exp; v.ctrl = ctrl;
        vecs.push_back(v);
    endfunction

`ifdef EX_MULDIV_EN
    task automatic run_div(input string name, input logic [5:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp);
        int            cnt;
        bit            bub_ok;
        logic [W+13:0] e_sb;
        @(negedge clk);
        drive(op, a, b, '0, 64'h2000, 5'd9, 4'b1000, 3'd2, 2'd1);
        #1;
        e_sb   = in_sb;
        cnt    = 0;
        bub_ok = 1'b1;
        while (outStallReq && cnt < 200) begin
            if (cnt > 0 && (outAluResult != '0 || out_sb != '0)) bub_ok = 1'b0;
            cnt++;
            @(negedge clk);
            #1;
        end
        if (outAluResult != '0 || out_sb != '0) bub_ok = 1'b0;
        check({name, ".stall_cycles"}, cnt, 65);
        check({name, ".bubbles"}, bub_ok, 1'b1);
        sb_q.push_back('{res: exp, store: b, sb: e_sb});
        @(negedge clk);
        bubble();
        #1;
        check_pop(name);
        @(negedge clk);
        #1;
        check({name, ".single_result"}, {outAluResult, outRegWrite, outStallReq}, '0);
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        add(6'b001100, 64'd5, 64'd7, 64'd0, 64'd12, 4'b1000);
        add(6'b000001, 64'h1000, 64'hAB, -64'd8, 64'hFF8, 4'b0010);
        add(6'b011010, 64'h7FFFFFFF, 64'd1, 64'd0, 64'hFFFFFFFF80000000, 4'b1000);
        add(6'b001101, 64'd3, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFE, 4'b1001);
        add(6'b001110, 64'd1, 64'h43, 64'd0, 64'd8, 4'b1000);
        add(6'b001111, -64'd1, 64'd1, 64'd0, 64'd1, 4'b1000);
        add(6'b010000, -64'd1, 64'd1, 64'd0, 64'd0, 4'b1000);
        add(6'b010001, 64'hF0F0, 64'hFF00, 64'd0, 64'h0FF0, 4'b1000);
        add(6'b010010, 64'h8000000000000000, 64'd4, 64'd0, 64'h0800000000000000, 4'b1000);
        add(6'b010011, 64'h8000000000000000, 64'd4, 64'd0, 64'hF800000000000000, 4'b1000);
        add(6'b010100, 64'hF0, 64'h0F, 64'd0, 64'hFF, 4'b1000);
        add(6'b010101, 64'hF0, 64'h3C, 64'd0, 64'h30, 4'b1000);
        add(6'b011011, 64'd0, 64'd1, 64'd0, 64'hFFFFFFFFFFFFFFFF, 4'b1000);
        add(6'b011100, 64'd1, 64'h3F, 64'd0, 64'hFFFFFFFF80000000, 4'b1000);
        add(6'b011101, 64'hFFFFFFFF80000000, 64'd4, 64'd0, 64'h08000000, 4'b1000);
        add(6'b011110, 64'hFFFFFFFF80000000, 64'd4, 64'd0, 64'hFFFFFFFFF8000000, 4'b1000);
        add(6'b010110, 64'h7FFFFFFF, 64'hFF, 64'd1, 64'hFFFFFFFF80000000, 4'b1000);
        add(6'b010111, 64'd3, 64'd0, 64'd2, 64'd12, 4'b1000);
        add(6'b011000, 64'h80000000, 64'd0, 64'd31, 64'd1, 4'b1000);
        add(6'b011001, 64'h80000000, 64'd0, 64'd31, 64'hFFFFFFFFFFFFFFFF, 4'b1000);
        add(6'b000000, 64'd5, 64'd7, 64'd3, 64'd0, 4'b1000);
        add(6'b111111, 64'd5, 64'd7, 64'd3, 64'd0, 4'b0101);
        add(6'b011111, -64'd3, 64'd7, 64'd0, MD ? 64'hFFFFFFFFFFFFFFEB : 64'd0, 4'b1000);
        add(6'b100000, -64'd1, -64'd1, 64'd0, 64'd0, 4'b1000);
        add(6'b100001, -64'd1, -64'd1, 64'd0, MD ? 64'hFFFFFFFFFFFFFFFF : 64'd0, 4'b1000);
        add(6'b100010, -64'd1, -64'd1, 64'd0, MD ? 64'hFFFFFFFFFFFFFFFE : 64'd0, 4'b1000);
        add(6'b100111, 64'h8000, 64'h10000, 64'd0, MD ? 64'hFFFFFFFF80000000 : 64'd0, 4'b1000);
`ifndef EX_MULDIV_EN
        add(6'b100011, -64'd20, 64'd3, 64'd0, 64'd0, 4'b1000);
        add(6'b100101, 64'd9, 64'd0, 64'd0, 64'd0, 4'b1000);
`endif

        reset = 1'b1;
        drive(6'b001100, 64'd5, 64'd7, 64'd0, 64'h44, 5'd3, 4'b1111, 3'd5, 2'd3);
        @(negedge clk);
        #1;
        check("reset.result", outAluResult, '0);
        check("reset.store", outStoreData, '0);
        check("reset.side", out_sb, '0);
        check("reset.stall", outStallReq, 1'b0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, 64'h1000 + 64'(i) * 4,
                  5'(i), vecs[i].ctrl, 3'(i), 2'(i));
            #1;
            if (sb_q.size() != 0) check_pop($sformatf("vec%0d", i - 1));
            check($sformatf("vec%0d.stall", i), outStallReq, 1'b0);
            sb_q.push_back('{res: vecs[i].exp, store: vecs[i].b, sb: in_sb});
        end
        @(negedge clk);
        bubble();
        #1;
        check_pop("vec_last");

`ifdef EX_MULDIV_EN
        run_div("div_neg", 6'b100011, -64'd20, 64'd3, -64'd6);
        run_div("rem_by0", 6'b100101, 64'd9, 64'd0, 64'd9);
        run_div("div_ovf", 6'b100011, 64'h8000000000000000, -64'd1, 64'h8000000000000000);
        run_div("div_by0", 6'b100011, -64'd7, 64'd0, 64'hFFFFFFFFFFFFFFFF);

        begin : reset_in_busy
            bit quiet;
            @(negedge clk);
            drive(6'b100011, 64'd1000, 64'd7, '0, 64'h3000, 5'd4, 4'b1000, 3'd0, 2'd0);
            for (int k = 0; k < 31; k++) @(negedge clk);
            reset = 1'b1;
            bubble();
            @(negedge clk);
            reset = 1'b0;
            #1;
            check("abort.stall", outStallReq, 1'b0);
            check("abort.outputs", {outAluResult, out_sb}, '0);
            quiet = 1'b1;
            for (int k = 0; k < 80; k++) begin
                @(negedge clk);
                #1;
                if (outStallReq || outAluResult != '0 || outRegWrite) quiet = 1'b0;
            end
            check("abort.no_result", quiet, 1'b1);
        end

        run_div("remw", 6'b101010, -64'd7, 64'd2, 64'hFFFFFFFFFFFFFFFF);
        run_div("divuw", 6'b101001, 64'hFFFFFFFFFFFFFFFE, 64'd2, 64'h7FFFFFFF);
        run_div("remu", 6'b100110, 64'd100, 64'd7, 64'd2);
        run_div("divu", 6'b100100, -64'd1, 64'd2, 64'h7FFFFFFFFFFFFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/execute1.md
EXECUTE1 -- requirements
Module: execute1

Interface
REQ-001 Parameter: BUS_DATA_WIDTH, default 64, datapath width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inAluControl  input  6  operation code from decode; 6'b000000 means no ALU operation (bubble).
REQ-005 inReadData1 / inReadData2  input  BUS_DATA_WIDTH each  rs1 and rs2 operand values.
REQ-006 inImm  input  BUS_DATA_WIDTH  sign-extended immediate.
REQ-007 inPc  input  BUS_DATA_WIDTH  instruction PC.
REQ-008 inDestRegister  input  5  rd index.
REQ-009 inRegWrite, inMemRead, inMemWrite, inMemOrReg  input  1 each  control sideband.
REQ-010 inLoadType  input  3  load sideband; inStoreType  input  2  store sideband.
REQ-011 outAluResult  output  BUS_DATA_WIDTH  registered result or effective address.
REQ-012 outStoreData  output  BUS_DATA_WIDTH  registered copy of inReadData2.
REQ-013 outPc, outDestRegister, outRegWrite, outMemRead, outMemWrite, outMemOrReg, outLoadType, outStoreType  output  widths as inputs  registered copies of the sideband.
REQ-014 outStallReq  output  1  combinational; upstream stages hold while it is high.

Function
REQ-015 The block is one pipeline stage: when not stalling, every output register SHALL load on each clk edge, giving 1-cycle latency for all non-divide operations.
REQ-016 Operand B SHALL be inImm for codes 000001 (load/store/addi address), 010110 (addiw), 010111 (slliw), 011000 (srliw) and 011001 (sraiw); it SHALL be inReadData2 for all other codes.
REQ-017 Single-cycle codes SHALL be implemented as follows:
- 001100 add; 001101 sub; 001110 sll; 001111 slt; 010000 sltu.
- 010001 xor; 010010 srl; 010011 sra; 010100 or; 010101 and.
- 011010 addw; 011011 subw; 011100 sllw; 011101 srlw; 011110 sraw.
- 010110–011001 immediate word variants (addiw, slliw, srliw, sraiw).
REQ-018 Shift amount SHALL be B[5:0] for 64-bit shifts and B[4:0] for word shifts.
REQ-019 Word ops SHALL compute on bits [31:0] and sign-extend bit 31 to BUS_DATA_WIDTH.
REQ-020 Unlisted codes, including 000000, SHALL produce outAluResult=0 with the sideband passed through unchanged.
REQ-021 Multiply codes SHALL be single-cycle:
- 011111 mul: low 64 bits of the product.
- 100000 mulh, 100001 mulhsu, 100010 mulhu: high 64 bits of the signed×signed, signed×unsigned and unsigned×unsigned 128-bit product respectively.
- 100111 mulw: low 32 bits of the product, sign-extended.
REQ-022 Divide codes SHALL use the multi-cycle unit: 100011 div, 100100 divu, 100101 rem, 100110 remu, 101000 divw, 101001 divuw, 101010 remw, 101011 remuw.
REQ-023 The divide FSM states SHALL be IDLE, BUSY and DONE.
REQ-024 IDLE with a divide code at input: latch the operands, the op and the sideband; count<=0; go to BUSY; outStallReq=1 this cycle; the output registers load a bubble (all zero).
REQ-025 BUSY: perform one restoring radix-2 step per cycle on unsigned magnitudes, 64 steps for all codes.
- outStallReq=1 throughout; outputs load a bubble each cycle.
- After the step with count==63, go to DONE.
REQ-026 DONE: outStallReq=0. At the edge, outputs load the sign-corrected quotient or remainder with the latched sideband, the instruction still present at the input is consumed (not restarted), and the FSM returns to IDLE.
REQ-027 Total divide occupancy is 66 cycles at the input.
REQ-028 Divide sign rules: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-029 Word divide variants SHALL use sign- or zero-extended [31:0] operands and sign-extend the 32-bit result.
REQ-030 Divide by zero SHALL give quotient all-ones and remainder equal to the dividend.
REQ-031 Signed overflow (most-negative ÷ −1) SHALL give quotient equal to the dividend and remainder 0.
REQ-032 outStallReq SHALL be 0 in every cycle not covered by REQ-024/REQ-025.

Reset
REQ-033 When reset is high at a clk edge, all output registers SHALL become 0, the FSM SHALL go to IDLE and count SHALL become 0.
REQ-034 Reset during BUSY or DONE SHALL abort the divide with no result written; outStallReq SHALL be 0 in the following cycle unless a new divide code is present at the input.

Configuration
REQ-035 Macro EX_MULDIV_EN defined: REQ-021 to REQ-031 apply.
REQ-036 Macro EX_MULDIV_EN undefined:
- Multiply and divide codes are treated as unlisted (result 0, per REQ-020).
- The divide FSM and multiplier are not synthesised.
- outStallReq is tied to 0.

Verification
REQ-037 Code 001100, rs1=5, rs2=7 → outAluResult=12 one cycle later; outRegWrite follows inRegWrite.
REQ-038 Code 000001, rs1=0x1000, imm=−8, inMemWrite=1, rs2=0xAB → outAluResult=0xFF8, outStoreData=0xAB, outMemWrite=1.
REQ-039 Code 011010, rs1=0x7FFFFFFF, rs2=1 → outAluResult=0xFFFFFFFF80000000.
REQ-040 Code 100011, rs1=−20, rs2=3, input held while stalled → outStallReq high for 65 cycles, then outAluResult=−6 written at the DONE edge, then exactly one result.
REQ-041 Code 100101, rs2=0, rs1=9 → remainder 9. Code 100011, rs1=0x8000000000000000, rs2=−1 → quotient 0x8000000000000000.
REQ-042 Assert reset at BUSY cycle 30 → outputs 0, no divide result ever appears, outStallReq=0 next cycle with a bubble at the input.
